// File: rtl/deser_queue_ctrl_if.sv
// rtl/deser_queue_ctrl_if.sv - handshake bundle between deserializer, controller and queue
interface deser_queue_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              data_ready;
    logic [DATA_W-1:0] deser_byte;
    logic              consume_req;
    logic              enqueue_out;
    logic [DATA_W-1:0] enq_data;
    logic              dequeue_out;
    logic              status_out;
    logic [3:0]        count_out;
    logic [7:0]        drop_count;
    logic              underrun_out;

    modport master (
        output data_ready, deser_byte, consume_req,
        input  enqueue_out, enq_data, dequeue_out, status_out,
               count_out, drop_count, underrun_out
    );

    modport slave (
        input  data_ready, deser_byte, consume_req,
        output enqueue_out, enq_data, dequeue_out, status_out,
               count_out, drop_count, underrun_out
    );
endinterface

// File: rtl/deser_queue_ctrl.sv
// rtl/deser_queue_ctrl.sv - arbitrates deserializer bytes and consumer requests onto a queue
module deser_queue_ctrl #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    deser_queue_ctrl_if.slave   bus
);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, ENQ, DEQ} state_t;

    state_t            state_q, state_d;
    logic              pend_enq_q, pend_enq_d;
    logic              pend_deq_q, pend_deq_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] enq_data_q, enq_data_d;
    logic [3:0]        count_q, count_d;
    logic [7:0]        drop_q, drop_d;
    logic              underrun_q, underrun_d;

    logic go_enq, go_deq, full_drop, clr_enq, ovw_drop;

    // Register all controller state; reset aborts any strobe in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_enq_q <= 1'b0;
            pend_deq_q <= 1'b0;
            hold_q     <= '0;
            enq_data_q <= '0;
            count_q    <= 4'd0;
            drop_q     <= 8'd0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_enq_q <= pend_enq_d;
            pend_deq_q <= pend_deq_d;
            hold_q     <= hold_d;
            enq_data_q <= enq_data_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state decision: enqueue wins over dequeue; a pending byte is committed
    // (pend_enq cleared) on entry to ENQ so a new byte may arrive during the strobe.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        go_enq     = 1'b0;
        go_deq     = 1'b0;
        full_drop  = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_enq_q && (count_q < DEPTH_C)) begin
                    state_d = ENQ;
                    go_enq  = 1'b1;
                end else if (pend_deq_q && (count_q != 4'd0)) begin
                    state_d = DEQ;
                    go_deq  = 1'b1;
                end else begin
                    // Reaching here with pend_enq means the queue is full.
                    if (pend_enq_q && !pend_deq_q) full_drop = 1'b1;
                    // Reaching here with pend_deq means the queue is empty.
                    if (pend_deq_q) underrun_d = 1'b1;
                end
            end
            ENQ: begin
                count_d = count_q + 4'd1;
                // Chain straight into a waiting dequeue so the strobes are back to back.
                if (pend_deq_q) begin
                    state_d = DEQ;
                    go_deq  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DEQ: begin
                count_d = count_q - 4'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending flags, hold register, enqueue data and saturating drop counter.
    always_comb begin
        clr_enq    = go_enq | full_drop;
        ovw_drop   = bus.data_ready & pend_enq_q & ~clr_enq;
        pend_enq_d = bus.data_ready | (pend_enq_q & ~clr_enq);
        pend_deq_d = bus.consume_req | (pend_deq_q & ~(go_deq | underrun_d));
        hold_d     = bus.data_ready ? bus.deser_byte : hold_q;
        enq_data_d = go_enq ? hold_q : enq_data_q;
        drop_d     = drop_q;
        if ((full_drop || ovw_drop) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    assign bus.enqueue_out  = (state_q == ENQ);
    assign bus.dequeue_out  = (state_q == DEQ);
    assign bus.enq_data     = enq_data_q;
    assign bus.count_out    = count_q;
    assign bus.drop_count   = drop_q;
    assign bus.underrun_out = underrun_q;
    assign bus.status_out   = ~pend_enq_q & (count_q < DEPTH_C);
endmodule

// File: tb/tb_deser_queue_ctrl.sv
// tb/tb_deser_queue_ctrl.sv - directed self-checking bench for deser_queue_ctrl
module tb_deser_queue_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total  = 0;
    int   passes = 0;

    deser_queue_ctrl_if #(.DATA_W(8)) bus ();

    deser_queue_ctrl #(.DEPTH(8), .DATA_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        bus.data_ready = 1'b1;
        bus.deser_byte = b;
        step();
        bus.data_ready = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic pop();
        bus.consume_req = 1'b1;
        step();
        bus.consume_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        bus.data_ready  = 1'b0;
        bus.deser_byte  = 8'h00;
        bus.consume_req = 1'b0;

        // reset state
        step();
        step();
        chk("rst_enq",      bus.enqueue_out, 0);
        chk("rst_deq",      bus.dequeue_out, 0);
        chk("rst_enq_data", bus.enq_data, 0);
        chk("rst_count",    bus.count_out, 0);
        chk("rst_drop",     bus.drop_count, 0);
        chk("rst_underrun", bus.underrun_out, 0);
        reset = 1'b0;
        chk("rst_status",   bus.status_out, 1);

        // single byte 0xA5, two-edge latency
        bus.data_ready = 1'b1;
        bus.deser_byte = 8'hA5;
        step();
        bus.data_ready = 1'b0;
        chk("a5_no_enq_yet", bus.enqueue_out, 0);
        chk("a5_status_pend", bus.status_out, 0);
        step();
        chk("a5_enq",      bus.enqueue_out, 1);
        chk("a5_no_deq",   bus.dequeue_out, 0);
        chk("a5_enq_data", bus.enq_data, 8'hA5);
        step();
        chk("a5_enq_fall", bus.enqueue_out, 0);
        chk("a5_count",    bus.count_out, 1);
        chk("a5_data_hold", bus.enq_data, 8'hA5);
        chk("a5_status",   bus.status_out, 1);

        // fill to DEPTH, then a ninth byte is dropped
        for (int i = 1; i < 8; i++) push(8'(8'h10 + i));
        chk("full_count",  bus.count_out, 8);
        chk("full_status", bus.status_out, 0);
        chk("full_last",   bus.enq_data, 8'h17);
        bus.data_ready = 1'b1;
        bus.deser_byte = 8'h3C;
        step();
        bus.data_ready = 1'b0;
        step();
        chk("ninth_no_enq", bus.enqueue_out, 0);
        chk("ninth_drop",   bus.drop_count, 1);
        step();
        chk("ninth_count",  bus.count_out, 8);
        chk("ninth_status", bus.status_out, 0);
        chk("ninth_data",   bus.enq_data, 8'h17);

        // drain to 3
        for (int i = 0; i < 5; i++) pop();
        chk("drain3_count", bus.count_out, 3);

        // simultaneous enqueue and consume: ENQ then DEQ back to back
        bus.data_ready  = 1'b1;
        bus.deser_byte  = 8'h11;
        bus.consume_req = 1'b1;
        step();
        bus.data_ready  = 1'b0;
        bus.consume_req = 1'b0;
        step();
        chk("both_enq",      bus.enqueue_out, 1);
        chk("both_enq_nodq", bus.dequeue_out, 0);
        chk("both_data",     bus.enq_data, 8'h11);
        step();
        chk("both_deq",      bus.dequeue_out, 1);
        chk("both_deq_noeq", bus.enqueue_out, 0);
        chk("both_mid_cnt",  bus.count_out, 4);
        step();
        chk("both_end_deq",  bus.dequeue_out, 0);
        chk("both_end_cnt",  bus.count_out, 3);

        // empty queue consume -> underrun pulse
        for (int i = 0; i < 3; i++) pop();
        chk("empty_count", bus.count_out, 0);
        bus.consume_req = 1'b1;
        step();
        bus.consume_req = 1'b0;
        step();
        chk("und_pulse", bus.underrun_out, 1);
        chk("und_no_deq", bus.dequeue_out, 0);
        chk("und_count", bus.count_out, 0);
        step();
        chk("und_fall",  bus.underrun_out, 0);
        chk("und_deq2",  bus.dequeue_out, 0);
        chk("und_count2", bus.count_out, 0);

        // fill again, then 300 back-to-back bytes saturate drop_count
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        chk("refill_count", bus.count_out, 8);
        bus.data_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.deser_byte = 8'(i);
            step();
        end
        bus.data_ready = 1'b0;
        step();
        step();
        chk("sat_drop",  bus.drop_count, 255);
        chk("sat_count", bus.count_out, 8);
        push(8'hEE);
        chk("sat_nowrap", bus.drop_count, 255);

        // reset in the middle of an ENQ cycle
        pop();
        chk("pre_rst_count", bus.count_out, 7);
        bus.data_ready = 1'b1;
        bus.deser_byte = 8'h77;
        step();
        bus.data_ready = 1'b0;
        step();
        chk("mid_enq", bus.enqueue_out, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_enq",      bus.enqueue_out, 0);
        chk("abort_count",    bus.count_out, 0);
        chk("abort_drop",     bus.drop_count, 0);
        chk("abort_enq_data", bus.enq_data, 0);
        chk("abort_status",   bus.status_out, 1);
        step();
        chk("abort_hold_cnt", bus.count_out, 0);

        // first edge after release is honoured
        reset = 1'b0;
        bus.data_ready = 1'b1;
        bus.deser_byte = 8'h5A;
        step();
        bus.data_ready = 1'b0;
        step();
        chk("post_rst_enq",  bus.enqueue_out, 1);
        chk("post_rst_data", bus.enq_data, 8'h5A);
        step();
        chk("post_rst_count", bus.count_out, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
